// File: rtl/match_window_counter.sv
// Counts 1010-detector matches over fixed windows of enabled cycles and
// reports each closed window's count on a valid/ready interface.
module match_window_counter #(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16,
  parameter int WIN_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             match_in,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_sat,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             overrun
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rpt_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] win_cnt_nx;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_nx;
  logic             acc_sat;
  logic             acc_sat_nx;

  logic [CNT_W-1:0] fin;
  logic             fin_sat;
  logic             acc_full;
  logic             bump;
  logic             close;
  logic             accept;

  rpt_state_e       state;
  rpt_state_e       state_nx;
  logic [CNT_W-1:0] data_nx;
  logic             sat_nx;
  logic             ovr_nx;

  assign close    = en & (win_cnt == WIN_LAST);
  assign accept   = (state == FULL) & cnt_ready;
  assign acc_full = (acc == CNT_MAX);
  assign bump     = match_in & ~acc_full;

  // Saturating add of this cycle's sample; also the close-time result.
  assign fin      = bump ? acc + CNT_W'(1) : acc;
  assign fin_sat  = acc_sat | (match_in & acc_full);

  always_comb begin
    win_cnt_nx = win_cnt;
    acc_nx     = acc;
    acc_sat_nx = acc_sat;
    if (en) begin
      if (close) begin
        win_cnt_nx = '0;
        acc_nx     = '0;
        acc_sat_nx = 1'b0;
      end else begin
        win_cnt_nx = win_cnt + WIN_W'(1);
        acc_nx     = fin;
        acc_sat_nx = fin_sat;
      end
    end
  end

  always_comb begin
    state_nx = state;
    data_nx  = cnt_data;
    sat_nx   = cnt_sat;
    ovr_nx   = overrun;
    unique case (state)
      EMPTY: begin
        if (close) begin
          state_nx = FULL;
          data_nx  = fin;
          sat_nx   = fin_sat;
        end
      end
      FULL: begin
        unique case (1'b1)
          close & accept: begin
            data_nx = fin;
            sat_nx  = fin_sat;
          end
          close & ~accept: begin
            ovr_nx = 1'b1;
          end
          ~close & accept: begin
            state_nx = EMPTY;
          end
          default: begin
            state_nx = FULL;
          end
        endcase
      end
      default: begin
        state_nx = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt  <= '0;
      acc      <= '0;
      acc_sat  <= 1'b0;
      state    <= EMPTY;
      cnt_data <= '0;
      cnt_sat  <= 1'b0;
      overrun  <= 1'b0;
    end else if (clr) begin
      win_cnt  <= '0;
      acc      <= '0;
      acc_sat  <= 1'b0;
      state    <= EMPTY;
      cnt_data <= '0;
      cnt_sat  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      win_cnt  <= win_cnt_nx;
      acc      <= acc_nx;
      acc_sat  <= acc_sat_nx;
      state    <= state_nx;
      cnt_data <= data_nx;
      cnt_sat  <= sat_nx;
      overrun  <= ovr_nx;
    end
  end

  assign cnt_valid = (state == FULL);

endmodule

// File: tb/tb_match_window_counter.sv
// Bench for match_window_counter: CNT_W=8 and CNT_W=3 instances on shared
// stimulus, checked against an unbounded-count window/report model.
module tb_match_window_counter;

  localparam int WL = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic match_in = 1'b0;
  logic cnt_ready = 1'b0;

  logic [7:0] d8;
  logic       s8, v8, o8;
  logic [2:0] d3;
  logic       s3, v3, o3;

  wire [10:0] ob8 = {v8, s8, o8, d8};
  wire [5:0]  ob3 = {v3, s3, o3, d3};

  always #5 clk = ~clk;

  match_window_counter #(.CNT_W(8), .WIN_LEN(WL), .WIN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .match_in(match_in),
    .cnt_data(d8), .cnt_sat(s8), .cnt_valid(v8), .cnt_ready(cnt_ready),
    .overrun(o8)
  );

  match_window_counter #(.CNT_W(3), .WIN_LEN(WL), .WIN_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .match_in(match_in),
    .cnt_data(d3), .cnt_sat(s3), .cnt_valid(v3), .cnt_ready(cnt_ready),
    .overrun(o3)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model: enabled cycles seen and raw matches in the open window.
  int m_n;
  int m_m;
  bit mv[2];
  bit ms[2];
  bit mo[2];
  int md[2];
  int mmax[2] = '{255, 7};
  logic [2:0] xh;

  task automatic model_reset();
    m_n = 0;
    m_m = 0;
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0; ms[i] = 0; mo[i] = 0; md[i] = 0;
    end
  endtask

  function automatic logic [16:0] expv();
    return {mv[0], ms[0], mo[0], 8'(md[0]), mv[1], ms[1], mo[1], 3'(md[1])};
  endfunction

  task automatic step();
    bit close;
    bit acc;
    int total;
    @(posedge clk);
    if (!rst_n || clr) begin
      model_reset();
    end else begin
      close = en && (m_n == WL - 1);
      total = m_m + int'(match_in);
      for (int i = 0; i < 2; i++) begin
        acc = mv[i] && cnt_ready;
        if (close) begin
          if (!mv[i] || acc) begin
            mv[i] = 1;
            md[i] = (total > mmax[i]) ? mmax[i] : total;
            ms[i] = (total > mmax[i]);
          end else begin
            mo[i] = 1;
          end
        end else if (acc) begin
          mv[i] = 0;
        end
      end
      if (en) begin
        if (close) begin
          m_n = 0;
          m_m = 0;
        end else begin
          m_n = m_n + 1;
          m_m = total;
        end
      end
    end
    #1;
  endtask

  // Detector stand-in: Mealy 1010 with overlap, advanced every edge.
  task automatic xstep(input bit x);
    match_in = (xh == 3'b101) && !x;
    step();
    xh = {xh[1:0], x};
  endtask

  task automatic fresh();
    clr = 1'b1;
    step();
    clr = 1'b0;
    xh = 3'b000;
    match_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    n_chk++;
    if ({ob8, ob3} !== 17'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want %h", {ob8, ob3}, 17'b0);
    end
    rst_n = 1'b1;
    en = 1'b1;
    cnt_ready = 1'b1;
  endtask

  task automatic test_single_match();
    bit seq[16] = '{1,0,1,0,0,0,0,0,0,0,0,0,0,0,0,0};
    fresh();
    cnt_ready = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      xstep(seq[i]);
      n_chk++;
      if ({ob8, ob3} !== expv()) begin
        n_fail++;
        $display("FAIL single_model step %0d got %h want %h", i, {ob8, ob3}, expv());
      end
      if (i == 14) begin
        n_chk++;
        if (v8 !== 1'b0) begin
          n_fail++;
          $display("FAIL single_early_valid got %b want 0", v8);
        end
      end
    end
    n_chk++;
    if ({v8, d8, s8} !== {1'b1, 8'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_report got v%b d%0d s%b want v1 d1 s0", v8, d8, s8);
    end
  endtask

  task automatic test_overlap();
    bit seq[16] = '{1,0,1,0,1,0,1,1,0,0,0,0,0,0,0,0};
    fresh();
    cnt_ready = 1'b1;
    for (int i = 0; i < 16; i++) xstep(seq[i]);
    n_chk++;
    if ({v8, d8} !== {1'b1, 8'd2}) begin
      n_fail++;
      $display("FAIL overlap_count got v%b d%0d want v1 d2", v8, d8);
    end
    for (int i = 0; i < 17; i++) begin
      xstep(1'b0);
      n_chk++;
      if ({ob8, ob3} !== expv()) begin
        n_fail++;
        $display("FAIL overlap_model step %0d got %h want %h", i, {ob8, ob3}, expv());
      end
    end
    n_chk++;
    if ({v8, d8} !== {1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL zero_window_pulse got v%b d%0d want v0 d0", v8, d8);
    end
  endtask

  task automatic test_saturate();
    fresh();
    cnt_ready = 1'b1;
    match_in = 1'b1;
    for (int i = 0; i < 16; i++) step();
    n_chk++;
    if ({d3, s3, d8, s8} !== {3'd7, 1'b1, 8'd16, 1'b0}) begin
      n_fail++;
      $display("FAIL sat_full got d3=%0d s3=%b d8=%0d s8=%b want 7 1 16 0", d3, s3, d8, s8);
    end
    for (int i = 0; i < 16; i++) begin
      match_in = (i < 7);
      step();
      n_chk++;
      if ({ob8, ob3} !== expv()) begin
        n_fail++;
        $display("FAIL sat_model step %0d got %h want %h", i, {ob8, ob3}, expv());
      end
    end
    match_in = 1'b0;
    n_chk++;
    if ({v3, d3, s3} !== {1'b1, 3'd7, 1'b0}) begin
      n_fail++;
      $display("FAIL sat_exact_max got v%b d%0d s%b want v1 d7 s0", v3, d3, s3);
    end
  endtask

  task automatic test_overrun();
    fresh();
    cnt_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      match_in = ((i % 16) == 3);
      step();
      if (i == 15) begin
        n_chk++;
        if ({v8, o8, d8} !== {1'b1, 1'b0, 8'd1}) begin
          n_fail++;
          $display("FAIL ovr_first got v%b o%b d%0d want v1 o0 d1", v8, o8, d8);
        end
      end
      if (i == 31 || i == 39) begin
        n_chk++;
        if ({v8, o8, d8} !== {1'b1, 1'b1, 8'd1}) begin
          n_fail++;
          $display("FAIL ovr_second got v%b o%b d%0d want v1 o1 d1", v8, o8, d8);
        end
      end
    end
    match_in = 1'b0;
    cnt_ready = 1'b1;
    step();
    n_chk++;
    if ({v8, o8} !== 2'b01) begin
      n_fail++;
      $display("FAIL ovr_accept got v%b o%b want v0 o1", v8, o8);
    end
    fresh();
    n_chk++;
    if ({o8, o3} !== 2'b00) begin
      n_fail++;
      $display("FAIL ovr_clr got %b%b want 00", o8, o3);
    end
  endtask

  task automatic test_enable_gap();
    fresh();
    cnt_ready = 1'b1;
    for (int i = 0; i < 21; i++) begin
      en = !(i >= 6 && i < 11);
      match_in = (i == 2) || !en;
      step();
      if (i == 19) begin
        n_chk++;
        if (v8 !== 1'b0) begin
          n_fail++;
          $display("FAIL gap_early got v%b want 0", v8);
        end
      end
    end
    en = 1'b1;
    match_in = 1'b0;
    n_chk++;
    if ({v8, d8} !== {1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL gap_report got v%b d%0d want v1 d1", v8, d8);
    end
  endtask

  task automatic test_back_to_back();
    fresh();
    cnt_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      match_in = (i == 1 || i == 5 || i == 17 || i == 19 || i == 21);
      cnt_ready = (i == 31);
      step();
    end
    match_in = 1'b0;
    cnt_ready = 1'b0;
    n_chk++;
    if ({v8, o8, d8} !== {1'b1, 1'b0, 8'd3}) begin
      n_fail++;
      $display("FAIL b2b_reload got v%b o%b d%0d want v1 o0 d3", v8, o8, d8);
    end
    n_chk++;
    if ({ob8, ob3} !== expv()) begin
      n_fail++;
      $display("FAIL b2b_model got %h want %h", {ob8, ob3}, expv());
    end
  endtask

  task automatic test_async_reset();
    fresh();
    cnt_ready = 1'b0;
    for (int i = 0; i < 21; i++) begin
      match_in = (i == 4);
      step();
    end
    match_in = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if ({ob8, ob3} !== 17'b0) begin
      n_fail++;
      $display("FAIL async_reset got %h want 0", {ob8, ob3});
    end
    step();
    rst_n = 1'b1;
    cnt_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      match_in = (i == 9);
      step();
      if (i == 14) begin
        n_chk++;
        if (v8 !== 1'b0) begin
          n_fail++;
          $display("FAIL rst_window_early got v%b want 0", v8);
        end
      end
    end
    match_in = 1'b0;
    n_chk++;
    if ({v8, d8} !== {1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL rst_window_report got v%b d%0d want v1 d1", v8, d8);
    end
  endtask

  task automatic test_random();
    fresh();
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(3) != 0);
      clr = ($urandom_range(150) == 0);
      if (i < 1500) begin
        match_in = ($urandom_range(2) == 0);
        cnt_ready = ($urandom_range(3) == 0);
      end else begin
        match_in = ($urandom_range(2) != 0);
        cnt_ready = ($urandom_range(3) != 0);
      end
      step();
      n_chk++;
      if ({ob8, ob3} !== expv()) begin
        n_fail++;
        $display("FAIL random step %0d got %h want %h", i, {ob8, ob3}, expv());
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    xh = 3'b000;
    model_reset();
    test_reset();
    test_single_match();
    test_overlap();
    test_saturate();
    test_overrun();
    test_enable_gap();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
